usb_command_decoder: RTL and testbench
======================================

Name: usb_command_decoder

Overview:
- Sits directly downstream of the USB command/reply FIFO block, in the CLK_48 domain.
- Consumes each 32-bit command word and applies writes to a bank of 16-bit control registers that drive the array-driver logic.
- Generates exactly one 32-bit reply per accepted command, handed back through the reply handshake under that block's backpressure.

Parameters:
- NUM_REGS, 16: number of 16-bit control registers; 1..256.
- REPLY_TIMEOUT, 4800: cycles a pending reply may wait for acceptance before it is discarded (100 us at 48 MHz).

Ports:
- CLK_48  input  1  system clock, 48 MHz.
- RESET_N  input  1  asynchronous, active-low reset.
- i_command  input  1  one-cycle strobe; i_cmd_data valid.
- i_cmd_data  input  32  command word: [31:24] opcode, [23:16] address, [15:0] value.
- i_busy  input  1  upstream reply path cannot accept (upstream overflow flag).
- o_reply  output  1  reply pending; held until accepted.
- o_reply_data  output  32  reply word; stable while o_reply=1.
- o_regs  output  NUM_REGS*16  flat register bank; reg k at [16k+15:16k].
- o_wr_strobe  output  1  one-cycle pulse per successful register write.
- o_wr_addr  output  8  address of that write; valid with o_wr_strobe.
- o_timeout  output  1  one-cycle pulse when a reply is discarded by timeout.

Behaviour:
- Reset (async assert, release sync to CLK_48):
  - All o_regs=0; o_reply=0; o_reply_data=0; o_wr_strobe=0; o_wr_addr=0; o_timeout=0.
  - Counters=0; skid empty; state IDLE.
- Opcodes:
  - 0x00 NOP: reply {0x80,addr,0x0000}.
  - 0x01 WRITE: if addr<NUM_REGS, reg[addr]<=value, o_wr_strobe pulses, reply {0x81,addr,value}; else no write, reply {0xFF,addr,value}.
  - 0x02 READ: if addr<NUM_REGS, reply {0x82,addr,reg[addr]}; else reply {0xFF,addr,0x0000}.
  - 0x03 STATUS: reply {0x83, 8'h00, cmd_count[7:0], drop_count[7:0]}.
  - Any other opcode: reply {0xFF,addr,value}.
- Counters (8 bits, wrap 255->0):
  - cmd_count increments per command executed.
  - drop_count increments per command lost to a full skid.
- States:
  - IDLE: on a command (from i_command, or from the skid if occupied; the skid has priority), execute in the same cycle. Register write and o_wr_strobe are registered, visible the next cycle. o_reply_data is loaded and o_reply=1 the next cycle. Go to PEND.
  - PEND: o_reply=1, data stable. Acceptance = o_reply & ~i_busy in a cycle. On acceptance, o_reply=0 next cycle; go to GAP. Timeout counter increments each PEND cycle. When it reaches REPLY_TIMEOUT-1 without acceptance: o_reply=0, o_timeout pulses, go to GAP. Acceptance on the same cycle wins over timeout.
  - GAP: exactly one cycle with o_reply=0, so the upstream busy flag can propagate. Then IDLE.
- Latency: command strobe in IDLE to o_reply=1 is 1 cycle. Command in PEND/GAP waits in the skid.
- Skid (1 entry):
  - i_command while not able to execute (PEND, GAP, or IDLE with skid occupied): stored if skid empty; otherwise the new command is dropped and drop_count increments.
  - i_command in the same cycle the skid is drained: stored into the skid.
- Write conflicts: writes only from executed commands, at most one per cycle; no conflict possible.
- Reset mid-PEND: reply is abandoned and o_reply drops immediately (async). Register bank returns to 0.
- Timeout counter width: clog2(REPLY_TIMEOUT+1); cleared on entry to PEND.

Test Plan:
- Reset, then i_command with 0x01_03_BEEF, i_busy=0:
  - Next cycle: o_wr_strobe=1, o_wr_addr=3, reg3=0xBEEF, o_reply=1, o_reply_data=0x8103BEEF.
  - Following cycle: o_reply=0.
- After the write above, i_command 0x02_03_0000 -> reply 0x8203BEEF. Then 0x02_20_0000 (NUM_REGS=16) -> 0xFF200000; no strobe.
- Hold i_busy=1 for 10 cycles after a reply is posted:
  - o_reply stays 1 with unchanged data.
  - Drop i_busy: accepted, o_reply=0 next cycle, one GAP cycle.
- While PEND, send 3 commands (0x01_00_0001, 0x01_01_0002, 0x01_02_0003):
  - First goes to the skid and executes after GAP.
  - Second and third are dropped; no strobe for 1 or 2.
  - STATUS then returns 0x83000202 (cmd_count includes the first write and the original command).
- i_busy held 1 for REPLY_TIMEOUT cycles:
  - o_timeout pulses once; o_reply=0.
  - Next command is serviced normally.
- Assert RESET_N=0 while PEND with reg5=0x1234:
  - o_reply=0 immediately; o_regs all 0.
  - After release, READ 5 returns 0x82050000.

Source files
------------

// File: rtl/usb_command_decoder.sv
// Command decoder behind the USB command/reply FIFO: executes 32-bit command words
// against a bank of 16-bit control registers and returns one reply per executed command.
module usb_command_decoder #(
    parameter int unsigned NUM_REGS      = 16,
    parameter int unsigned REPLY_TIMEOUT = 4800
) (
    input  logic                     CLK_48,
    input  logic                     RESET_N,
    input  logic                     i_command,
    input  logic [31:0]              i_cmd_data,
    input  logic                     i_busy,
    output logic                     o_reply,
    output logic [31:0]              o_reply_data,
    output logic [NUM_REGS*16-1:0]   o_regs,
    output logic                     o_wr_strobe,
    output logic [7:0]               o_wr_addr,
    output logic                     o_timeout
);

    localparam int unsigned RW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned TW = $clog2(REPLY_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(REPLY_TIMEOUT - 1);

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;

    typedef struct packed {
        logic [7:0]    opcode;
        logic [7:0]    addr;
        logic [RW-1:0] value;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_skid_vld;
    logic [DW-1:0]   r_skid_data;
    logic [7:0]      r_cmd_cnt;
    logic [7:0]      r_drop_cnt;
    logic [TW-1:0]   r_tcnt;
    logic            r_reply;
    logic [DW-1:0]   r_reply_data;
    logic            r_wr_strobe;
    logic [7:0]      r_wr_addr;
    logic            r_timeout;
    logic [RW-1:0]   r_regs [NUM_REGS];

    state_t          w_state_n;
    logic            w_skid_vld_n;
    logic [DW-1:0]   w_skid_data_n;
    logic [7:0]      w_cmd_cnt_n;
    logic [7:0]      w_drop_cnt_n;
    logic [TW-1:0]   w_tcnt_n;
    logic            w_reply_n;
    logic [DW-1:0]   w_reply_data_n;
    logic            w_timeout_n;
    logic            w_wr_en;
    logic [7:0]      w_wr_addr_n;
    cmd_t            w_cmd;
    logic            w_in_range;
    logic [RW-1:0]   w_rd_val;
    logic [DW-1:0]   w_reply_word;
    logic            w_wr_ok;

    // Decode of the command that would execute this cycle (skid has priority)
    always_comb begin
        w_cmd        = cmd_t'(r_skid_vld ? r_skid_data : i_cmd_data);
        w_in_range   = (9'(w_cmd.addr) < 9'(NUM_REGS));
        w_rd_val     = w_in_range ? r_regs[AW'(w_cmd.addr)] : '0;
        w_wr_ok      = 1'b0;
        w_reply_word = {8'hFF, w_cmd.addr, w_cmd.value};
        case (w_cmd.opcode)
            OP_NOP:    w_reply_word = {8'h80, w_cmd.addr, 16'h0000};
            OP_WRITE: begin
                if (w_in_range) begin
                    w_wr_ok      = 1'b1;
                    w_reply_word = {8'h81, w_cmd.addr, w_cmd.value};
                end
            end
            OP_READ: begin
                if (w_in_range) w_reply_word = {8'h82, w_cmd.addr, w_rd_val};
                else            w_reply_word = {8'hFF, w_cmd.addr, 16'h0000};
            end
            OP_STATUS: w_reply_word = {8'h83, 8'h00, r_cmd_cnt, r_drop_cnt};
            default:   w_reply_word = {8'hFF, w_cmd.addr, w_cmd.value};
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_n      = r_state;
        w_skid_vld_n   = r_skid_vld;
        w_skid_data_n  = r_skid_data;
        w_cmd_cnt_n    = r_cmd_cnt;
        w_drop_cnt_n   = r_drop_cnt;
        w_tcnt_n       = r_tcnt;
        w_reply_n      = r_reply;
        w_reply_data_n = r_reply_data;
        w_timeout_n    = 1'b0;
        w_wr_en        = 1'b0;
        w_wr_addr_n    = r_wr_addr;

        case (r_state)
            ST_IDLE: begin
                if (r_skid_vld || i_command) begin
                    w_state_n      = ST_PEND;
                    w_reply_n      = 1'b1;
                    w_reply_data_n = w_reply_word;
                    w_tcnt_n       = '0;
                    w_cmd_cnt_n    = r_cmd_cnt + 8'd1;
                    w_wr_en        = w_wr_ok;
                    if (w_wr_ok) w_wr_addr_n = w_cmd.addr;
                    // Skid drained this cycle; a simultaneous strobe refills it
                    if (r_skid_vld) begin
                        w_skid_vld_n = i_command;
                        if (i_command) w_skid_data_n = i_cmd_data;
                    end
                end
            end
            ST_PEND: begin
                if (!i_busy) begin
                    w_reply_n = 1'b0;
                    w_state_n = ST_GAP;
                end else if (r_tcnt == TIMEOUT_LAST) begin
                    w_reply_n   = 1'b0;
                    w_timeout_n = 1'b1;
                    w_state_n   = ST_GAP;
                end else begin
                    w_tcnt_n = r_tcnt + TW'(1);
                end
            end
            ST_GAP:  w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase

        if (i_command && (r_state != ST_IDLE)) begin
            if (!r_skid_vld) begin
                w_skid_vld_n  = 1'b1;
                w_skid_data_n = i_cmd_data;
            end else begin
                w_drop_cnt_n = r_drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= ST_IDLE;
            r_skid_vld   <= 1'b0;
            r_skid_data  <= '0;
            r_cmd_cnt    <= '0;
            r_drop_cnt   <= '0;
            r_tcnt       <= '0;
            r_reply      <= 1'b0;
            r_reply_data <= '0;
            r_wr_strobe  <= 1'b0;
            r_wr_addr    <= '0;
            r_timeout    <= 1'b0;
            for (int unsigned k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else begin
            r_state      <= w_state_n;
            r_skid_vld   <= w_skid_vld_n;
            r_skid_data  <= w_skid_data_n;
            r_cmd_cnt    <= w_cmd_cnt_n;
            r_drop_cnt   <= w_drop_cnt_n;
            r_tcnt       <= w_tcnt_n;
            r_reply      <= w_reply_n;
            r_reply_data <= w_reply_data_n;
            r_wr_strobe  <= w_wr_en;
            r_wr_addr    <= w_wr_addr_n;
            r_timeout    <= w_timeout_n;
            if (w_wr_en) r_regs[AW'(w_cmd.addr)] <= w_cmd.value;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_REGS; k++) o_regs[k*RW +: RW] = r_regs[k];
    end

    assign o_reply      = r_reply;
    assign o_reply_data = r_reply_data;
    assign o_wr_strobe  = r_wr_strobe;
    assign o_wr_addr    = r_wr_addr;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_usb_command_decoder.sv
// Directed and random checks of usb_command_decoder against a transaction-level reference.
module tb_usb_command_decoder;

    localparam int unsigned NUM_REGS      = 16;
    localparam int unsigned REPLY_TIMEOUT = 4800;

    logic                   clk;
    logic                   rst_n;
    logic                   i_command;
    logic [31:0]            i_cmd_data;
    logic                   i_busy;
    logic                   o_reply;
    logic [31:0]            o_reply_data;
    logic [NUM_REGS*16-1:0] o_regs;
    logic                   o_wr_strobe;
    logic [7:0]             o_wr_addr;
    logic                   o_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_regs [NUM_REGS];
    logic [31:0] m_waiting [$];
    int          m_cmd_cnt, m_drop_cnt, m_pend_cycles;
    bit          m_pending, m_gap;
    logic        m_reply, m_strobe, m_timeout;
    logic [31:0] m_reply_data;
    logic [7:0]  m_waddr;

    usb_command_decoder #(.NUM_REGS(NUM_REGS), .REPLY_TIMEOUT(REPLY_TIMEOUT)) dut (
        .CLK_48       (clk),
        .RESET_N      (rst_n),
        .i_command    (i_command),
        .i_cmd_data   (i_cmd_data),
        .i_busy       (i_busy),
        .o_reply      (o_reply),
        .o_reply_data (o_reply_data),
        .o_regs       (o_regs),
        .o_wr_strobe  (o_wr_strobe),
        .o_wr_addr    (o_wr_addr),
        .o_timeout    (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS*16-1:0] model_bank();
        logic [NUM_REGS*16-1:0] b;
        b = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) b[k*16 +: 16] = m_regs[k];
        return b;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < int'(NUM_REGS); k++) m_regs[k] = 16'h0;
        m_waiting.delete();
        m_cmd_cnt = 0; m_drop_cnt = 0; m_pend_cycles = 0;
        m_pending = 0; m_gap = 0;
        m_reply = 0; m_reply_data = 0; m_strobe = 0; m_timeout = 0; m_waddr = 0;
    endfunction

    // Executes one command word as the spec's opcode table describes
    function automatic void model_exec(input logic [31:0] c);
        int          op, a;
        logic [15:0] v;
        logic [7:0]  a8;
        op = int'(c[31:24]);
        a  = int'(c[23:16]);
        a8 = c[23:16];
        v  = c[15:0];
        if (op == 0)
            m_reply_data = {8'h80, a8, 16'h0000};
        else if (op == 1 && a < int'(NUM_REGS)) begin
            m_regs[a] = v;
            m_strobe = 1;
            m_waddr = a8;
            m_reply_data = {8'h81, a8, v};
        end else if (op == 2 && a < int'(NUM_REGS))
            m_reply_data = {8'h82, a8, m_regs[a]};
        else if (op == 2)
            m_reply_data = {8'hFF, a8, 16'h0000};
        else if (op == 3)
            m_reply_data = {8'h83, 8'h00, 8'(m_cmd_cnt % 256), 8'(m_drop_cnt % 256)};
        else
            m_reply_data = {8'hFF, a8, v};
        m_cmd_cnt++;
        m_reply = 1;
        m_pending = 1;
        m_pend_cycles = 0;
    endfunction

    // Advances the reference by one clock given the inputs seen at that edge
    function automatic void model_step(input logic c, input logic [31:0] d, input logic b);
        logic [31:0] w;
        m_strobe = 0;
        m_timeout = 0;
        if (!m_pending && !m_gap) begin
            if (m_waiting.size() > 0) begin
                w = m_waiting.pop_front();
                if (c) m_waiting.push_back(d);
                model_exec(w);
            end else if (c) begin
                model_exec(d);
            end
        end else begin
            if (c) begin
                if (m_waiting.size() == 0) m_waiting.push_back(d);
                else m_drop_cnt++;
            end
            if (m_gap) m_gap = 0;
            else if (!b) begin
                m_reply = 0; m_pending = 0; m_gap = 1;
            end else if (m_pend_cycles == int'(REPLY_TIMEOUT) - 1) begin
                m_reply = 0; m_pending = 0; m_gap = 1; m_timeout = 1;
            end else m_pend_cycles++;
        end
    endfunction

    task automatic check_all();
        chk("reply", 256'(o_reply), 256'(m_reply));
        chk("reply_data", 256'(o_reply_data), 256'(m_reply_data));
        chk("wr_strobe", 256'(o_wr_strobe), 256'(m_strobe));
        if (m_strobe) chk("wr_addr", 256'(o_wr_addr), 256'(m_waddr));
        chk("timeout", 256'(o_timeout), 256'(m_timeout));
        chk("regs", 256'(o_regs), 256'(model_bank()));
    endtask

    task automatic cyc(input logic c, input logic [31:0] d, input logic b);
        i_command = c; i_cmd_data = d; i_busy = b;
        @(posedge clk);
        model_step(c, d, b);
        #1;
        check_all();
        i_command = 1'b0; i_cmd_data = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_command = 1'b0; i_cmd_data = 32'h0; i_busy = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        int          to_pulses, hi_cnt;
        logic [31:0] rd, hold;
        logic [7:0]  op, ad;

        rst_n = 1'b0; i_command = 1'b0; i_cmd_data = 32'h0; i_busy = 1'b0;
        model_reset();
        do_reset();
        chk("rst_reply", 256'(o_reply), 256'(0));
        chk("rst_regs", 256'(o_regs), 256'(0));

        // Write then immediate accept
        cyc(1'b1, 32'h0103BEEF, 1'b0);
        chk("wr_reply_data", 256'(o_reply_data), 256'(32'h8103BEEF));
        chk("wr_strobe_c", 256'(o_wr_strobe), 256'(1));
        chk("wr_addr_c", 256'(o_wr_addr), 256'(3));
        chk("wr_reg3", 256'(o_regs[3*16 +: 16]), 256'(16'hBEEF));
        cyc(1'b0, 32'h0, 1'b0);
        chk("wr_reply_clr", 256'(o_reply), 256'(0));
        cyc(1'b0, 32'h0, 1'b0);

        // Reads in and out of range
        cyc(1'b1, 32'h02030000, 1'b0);
        chk("rd3", 256'(o_reply_data), 256'(32'h8203BEEF));
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h02200000, 1'b0);
        chk("rd_oor", 256'(o_reply_data), 256'(32'hFF200000));
        chk("rd_oor_nostrobe", 256'(o_wr_strobe), 256'(0));
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);

        // Backpressure holds the reply
        cyc(1'b1, 32'h00550000, 1'b1);
        hold = o_reply_data;
        chk("nop_reply", 256'(hold), 256'(32'h80550000));
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("busy_hold", 256'({o_reply, o_reply_data}), 256'({1'b1, hold}));
        end
        cyc(1'b0, 32'h0, 1'b0);
        chk("busy_release", 256'(o_reply), 256'(0));
        cyc(1'b0, 32'h0, 1'b0);

        // Skid and drops, from fresh counters
        do_reset();
        cyc(1'b1, 32'h00000000, 1'b1);
        cyc(1'b1, 32'h01000001, 1'b1);
        cyc(1'b1, 32'h01010002, 1'b1);
        cyc(1'b1, 32'h01020003, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("skid_exec_strobe", 256'({o_wr_strobe, o_wr_addr}), 256'({1'b1, 8'h00}));
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h03000000, 1'b0);
        chk("status", 256'(o_reply_data), 256'(32'h83000202));
        chk("dropped_regs", 256'(o_regs[16 +: 32]), 256'(0));
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);

        // Reply timeout
        to_pulses = 0; hi_cnt = 0;
        cyc(1'b1, 32'h00010000, 1'b1);
        if (o_reply) hi_cnt++;
        for (int i = 0; i < int'(REPLY_TIMEOUT) + 4; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            if (o_timeout) to_pulses++;
            if (o_reply) hi_cnt++;
        end
        chk("timeout_pulses", 256'(to_pulses), 256'(1));
        chk("timeout_hi_cycles", 256'(hi_cnt), 256'(REPLY_TIMEOUT));
        chk("timeout_reply_low", 256'(o_reply), 256'(0));
        cyc(1'b1, 32'h0107CAFE, 1'b0);
        chk("post_timeout_write", 256'(o_reply_data), 256'(32'h8107CAFE));
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);

        // Reset while a reply is pending
        cyc(1'b1, 32'h01051234, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h00000000, 1'b1);
        chk("pend_before_rst", 256'(o_reply), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_reply", 256'(o_reply), 256'(0));
        chk("async_rst_regs", 256'(o_regs), 256'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h02050000, 1'b0);
        chk("rd5_after_rst", 256'(o_reply_data), 256'(32'h82050000));
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);

        // Random traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            op = 8'($urandom_range(0, 4));
            ad = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 19));
            rd = {op, ad, 16'($urandom)};
            cyc(($urandom_range(0, 9) < 3), rd, ($urandom_range(0, 9) < 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
